// File: rtl/thrust_velocity_ctrl_if.sv
// Command / velocity bus of the thrust velocity controller.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_mode, cmd_accel and cmd_steps are sampled
// only on that edge. cmd_ready never depends on cmd_valid. tick and
// cmd_abort are level strobes sampled every edge. vel_valid is a one-cycle
// pulse with no back-pressure; vel is stable between pulses unless a reset
// intervenes.
interface thrust_velocity_ctrl_if #(
  parameter int VW = 16,
  parameter int AW = 8
);
  logic          tick;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [AW-1:0] cmd_accel;
  logic [AW-1:0] cmd_steps;
  logic          cmd_abort;
  logic [VW-1:0] vel;
  logic          vel_valid;
  logic          busy;
  logic          sat;
  logic [1:0]    dbg_state;

  modport master (
    output tick, cmd_valid, cmd_mode, cmd_accel, cmd_steps, cmd_abort,
    input  cmd_ready, vel, vel_valid, busy, sat, dbg_state
  );

  modport slave (
    input  tick, cmd_valid, cmd_mode, cmd_accel, cmd_steps, cmd_abort,
    output cmd_ready, vel, vel_valid, busy, sat, dbg_state
  );
endinterface

// File: rtl/thrust_velocity_ctrl.sv
// Thrust velocity controller: integrates a commanded acceleration into a
// signed, saturating axis velocity on each physics tick, or brakes the
// velocity toward zero without crossing it.
module thrust_velocity_ctrl #(
  parameter int VW = 16,
  parameter int AW = 8
) (
  input logic                   clk,
  input logic                   rst,
  thrust_velocity_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_BRAKE = 2'd2
  } state_t;

  // Saturation limits, at VW+1 bits for comparison and at VW bits for loading.
  localparam logic signed [VW:0] C_MAX   = {2'b00, {(VW-1){1'b1}}};
  localparam logic signed [VW:0] C_MIN   = {2'b11, {(VW-1){1'b0}}};
  localparam logic [VW-1:0]      C_MAX_V = {1'b0, {(VW-1){1'b1}}};
  localparam logic [VW-1:0]      C_MIN_V = {1'b1, {(VW-1){1'b0}}};

  state_t        r_state;
  logic [VW-1:0] r_vel;
  logic          r_vel_valid;
  logic          r_sat;
  logic [1:0]    r_mode;
  logic [AW-1:0] r_accel;
  logic [AW-1:0] r_steps;

  // One extra bit keeps every sum, difference and |vel| exact, including
  // |-2^(VW-1)|, so clamping can be decided after the fact.
  logic signed [VW:0] w_vel_ext;
  logic signed [VW:0] w_accel_ext;
  logic signed [VW:0] w_inc;
  logic signed [VW:0] w_dec;
  logic signed [VW:0] w_apply_full;
  logic signed [VW:0] w_abs;
  logic               w_apply_hi;
  logic               w_apply_lo;
  logic [VW-1:0]      w_apply_vel;
  logic [VW-1:0]      w_brake_vel;
  logic               w_brake_zero;

  assign w_vel_ext    = {r_vel[VW-1], r_vel};
  assign w_accel_ext  = {{(VW+1-AW){1'b0}}, r_accel};
  assign w_inc        = w_vel_ext + w_accel_ext;
  assign w_dec        = w_vel_ext - w_accel_ext;
  assign w_apply_full = (r_mode == 2'b10) ? w_dec : w_inc;
  assign w_apply_hi   = (w_apply_full > C_MAX);
  assign w_apply_lo   = (w_apply_full < C_MIN);
  assign w_apply_vel  = w_apply_hi ? C_MAX_V :
                        w_apply_lo ? C_MIN_V : w_apply_full[VW-1:0];
  assign w_abs        = r_vel[VW-1] ? -w_vel_ext : w_vel_ext;
  // Step toward zero; only used when |vel| > accel, so no sign crossing.
  assign w_brake_vel  = r_vel[VW-1] ? w_inc[VW-1:0] : w_dec[VW-1:0];
  assign w_brake_zero = (r_accel == '0) || (w_abs <= w_accel_ext);

  assign bus.cmd_ready = (r_state == S_IDLE) && !rst;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.vel       = r_vel;
  assign bus.vel_valid = r_vel_valid;
  assign bus.sat       = r_sat;
  assign bus.dbg_state = r_state;

  // Control FSM with velocity, step counter and flags; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vel       <= '0;
      r_vel_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_mode      <= 2'b00;
      r_accel     <= '0;
      r_steps     <= '0;
    end else begin
      // Every tick yields a fresh sample, whatever the state does with it.
      r_vel_valid <= bus.tick;
      unique case (r_state)
        S_IDLE: begin
          // Abort is meaningless here, and a tick never applies the
          // command accepted in the same cycle.
          if (bus.cmd_valid) begin
            r_sat   <= 1'b0;
            r_mode  <= bus.cmd_mode;
            r_accel <= bus.cmd_accel;
            r_steps <= bus.cmd_steps;
            case (bus.cmd_mode)
              2'b01, 2'b10: if (bus.cmd_steps != '0) r_state <= S_APPLY;
              2'b11:        r_state <= S_BRAKE;
              default:      r_state <= S_IDLE;
            endcase
          end
        end
        S_APPLY: begin
          if (bus.cmd_abort) begin
            r_state <= S_IDLE;
          end else if (bus.tick) begin
            r_vel   <= w_apply_vel;
            r_steps <= r_steps - AW'(1);
            if (w_apply_hi || w_apply_lo) r_sat <= 1'b1;
            if (r_steps == AW'(1)) r_state <= S_IDLE;
          end
        end
        S_BRAKE: begin
          if (bus.cmd_abort) begin
            r_state <= S_IDLE;
          end else if (bus.tick) begin
            if (w_brake_zero) begin
              r_vel   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_vel <= w_brake_vel;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thrust_velocity_ctrl.sv
// Bench for thrust_velocity_ctrl: directed scenarios with known velocity
// traces, then a long randomized run against an integer reference model.
module tb_thrust_velocity_ctrl;

  localparam int VW   = 16;
  localparam int AW   = 8;
  localparam int VMAX = 32767;
  localparam int VMIN = -32768;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thrust_velocity_ctrl_if #(.VW(VW), .AW(AW)) tv ();

  thrust_velocity_ctrl #(.VW(VW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tv.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // A command is either running (accelerate, decelerate or brake) or not.
  int m_vel   = 0;
  bit m_vv    = 0;
  bit m_sat   = 0;
  bit m_busy  = 0;
  int m_kind  = 0;
  int m_acc   = 0;
  int m_left  = 0;

  task automatic model_edge();
    int nv;
    int mag;
    if (rst) begin
      m_vel = 0; m_vv = 0; m_sat = 0; m_busy = 0; m_kind = 0; m_left = 0;
    end else begin
      m_vv = tv.tick;
      if (!m_busy) begin
        if (tv.cmd_valid) begin
          m_sat = 0;
          m_acc = int'(tv.cmd_accel);
          if (tv.cmd_mode == 2'b11) begin
            m_busy = 1; m_kind = 3;
          end else if (tv.cmd_mode != 2'b00 && tv.cmd_steps != 0) begin
            m_busy = 1; m_kind = int'(tv.cmd_mode); m_left = int'(tv.cmd_steps);
          end
        end
      end else if (tv.cmd_abort) begin
        m_busy = 0;
      end else if (tv.tick) begin
        if (m_kind == 3) begin
          mag = (m_vel < 0) ? -m_vel : m_vel;
          if (m_acc == 0 || mag <= m_acc) begin
            m_vel = 0; m_busy = 0;
          end else begin
            m_vel = (m_vel < 0) ? m_vel + m_acc : m_vel - m_acc;
          end
        end else begin
          nv = (m_kind == 1) ? m_vel + m_acc : m_vel - m_acc;
          if (nv > VMAX) begin nv = VMAX; m_sat = 1; end
          if (nv < VMIN) begin nv = VMIN; m_sat = 1; end
          m_vel  = nv;
          m_left = m_left - 1;
          if (m_left == 0) m_busy = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock: update the model from the driven inputs, then sample
  // the DUT 1 ns after the rising edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] mode, input int accel, input int steps);
    tv.cmd_valid = 1'b1;
    tv.cmd_mode  = mode;
    tv.cmd_accel = AW'(accel);
    tv.cmd_steps = AW'(steps);
    step();
    tv.cmd_valid = 1'b0;
  endtask

  task automatic do_tick();
    tv.tick = 1'b1;
    step();
    tv.tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tv.tick = 1'b1; tv.cmd_valid = 1'b1; tv.cmd_mode = 2'b01;
    tv.cmd_accel = 8'd5; tv.cmd_steps = 8'd3; tv.cmd_abort = 1'b0;
    rst = 1'b1;
    step(); step(); step();
    n_checks++; if (tv.vel !== 16'(0)) begin n_errors++; $display("FAIL rst_vel got %0d exp 0", $signed(tv.vel)); end
    n_checks++; if (tv.vel_valid !== 1'b0) begin n_errors++; $display("FAIL rst_vv got %b exp 0", tv.vel_valid); end
    n_checks++; if (tv.busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy got %b exp 0", tv.busy); end
    n_checks++; if (tv.cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready got %b exp 0", tv.cmd_ready); end
    n_checks++; if (tv.sat !== 1'b0) begin n_errors++; $display("FAIL rst_sat got %b exp 0", tv.sat); end
    tv.tick = 1'b0; tv.cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (tv.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_rise got %b exp 1", tv.cmd_ready); end
  endtask

  task automatic test_accel();
    int exp_v[4] = '{10, 20, 30, 30};
    int exp_b[4] = '{1, 1, 0, 0};
    int pulses = 0;
    send_cmd(2'b01, 10, 3);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      if (tv.vel_valid === 1'b1) pulses++;
      n_checks++; if (tv.vel !== 16'(exp_v[i])) begin n_errors++; $display("FAIL accel_vel%0d got %0d exp %0d", i, $signed(tv.vel), exp_v[i]); end
      n_checks++; if (tv.busy !== 1'(exp_b[i])) begin n_errors++; $display("FAIL accel_busy%0d got %b exp %0d", i, tv.busy, exp_b[i]); end
      step();
      n_checks++; if (tv.vel_valid !== 1'b0) begin n_errors++; $display("FAIL accel_vv_low%0d got %b exp 0", i, tv.vel_valid); end
    end
    n_checks++; if (pulses != 4) begin n_errors++; $display("FAIL accel_pulses got %0d exp 4", pulses); end
  endtask

  task automatic test_saturation();
    do_reset();
    send_cmd(2'b01, 255, 128);
    for (int i = 0; i < 128; i++) do_tick();
    send_cmd(2'b01, 120, 1);
    do_tick();
    n_checks++; if (tv.vel !== 16'(32760)) begin n_errors++; $display("FAIL sat_pre got %0d exp 32760", $signed(tv.vel)); end
    send_cmd(2'b01, 20, 2);
    for (int i = 0; i < 2; i++) begin
      do_tick();
      n_checks++; if (tv.vel !== 16'(32767)) begin n_errors++; $display("FAIL sat_vel%0d got %0d exp 32767", i, $signed(tv.vel)); end
      n_checks++; if (tv.sat !== 1'b1) begin n_errors++; $display("FAIL sat_flag%0d got %b exp 1", i, tv.sat); end
    end
    step();
    n_checks++; if (tv.sat !== 1'b1) begin n_errors++; $display("FAIL sat_sticky got %b exp 1", tv.sat); end
    send_cmd(2'b10, 7, 1);
    n_checks++; if (tv.sat !== 1'b0) begin n_errors++; $display("FAIL sat_clear got %b exp 0", tv.sat); end
    do_tick();
    n_checks++; if (tv.vel !== 16'(32760)) begin n_errors++; $display("FAIL sat_after got %0d exp 32760", $signed(tv.vel)); end
  endtask

  task automatic test_brake();
    int exp_v[3] = '{-15, -5, 0};
    do_reset();
    send_cmd(2'b10, 25, 1);
    do_tick();
    n_checks++; if (tv.vel !== 16'(-25)) begin n_errors++; $display("FAIL brake_pre got %0d exp -25", $signed(tv.vel)); end
    send_cmd(2'b11, 10, 0);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      n_checks++; if (tv.vel !== 16'(exp_v[i])) begin n_errors++; $display("FAIL brake_vel%0d got %0d exp %0d", i, $signed(tv.vel), exp_v[i]); end
      n_checks++; if (tv.busy !== 1'(i < 2)) begin n_errors++; $display("FAIL brake_busy%0d got %b exp %0d", i, tv.busy, (i < 2)); end
    end
    do_tick();
    n_checks++; if (tv.vel !== 16'(0)) begin n_errors++; $display("FAIL brake_hold got %0d exp 0", $signed(tv.vel)); end
  endtask

  task automatic test_abort();
    do_reset();
    send_cmd(2'b01, 5, 10);
    do_tick();
    tv.tick = 1'b1; tv.cmd_abort = 1'b1;
    step();
    tv.tick = 1'b0; tv.cmd_abort = 1'b0;
    n_checks++; if (tv.vel !== 16'(5)) begin n_errors++; $display("FAIL abort_vel got %0d exp 5", $signed(tv.vel)); end
    n_checks++; if (tv.vel_valid !== 1'b1) begin n_errors++; $display("FAIL abort_vv got %b exp 1", tv.vel_valid); end
    n_checks++; if (tv.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b exp 0", tv.busy); end
    n_checks++; if (tv.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL abort_ready got %b exp 1", tv.cmd_ready); end
    do_tick();
    n_checks++; if (tv.vel !== 16'(5)) begin n_errors++; $display("FAIL abort_idle_tick got %0d exp 5", $signed(tv.vel)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_cmd(2'b01, 250, 2);
    do_tick(); do_tick();
    send_cmd(2'b11, 1, 0);
    n_checks++; if (tv.vel !== 16'(500) || tv.busy !== 1'b1) begin n_errors++; $display("FAIL rmid_pre got vel %0d busy %b exp 500 1", $signed(tv.vel), tv.busy); end
    rst = 1'b1; tv.tick = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (tv.vel !== 16'(0)) begin n_errors++; $display("FAIL rmid_vel%0d got %0d exp 0", i, $signed(tv.vel)); end
      n_checks++; if (tv.vel_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_vv%0d got %b exp 0", i, tv.vel_valid); end
      n_checks++; if (tv.busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy%0d got %b exp 0", i, tv.busy); end
    end
    rst = 1'b0; tv.tick = 1'b0;
    step();
  endtask

  task automatic test_degenerate();
    do_reset();
    send_cmd(2'b01, 40, 1);
    do_tick();
    send_cmd(2'b01, 9, 0);
    n_checks++; if (tv.busy !== 1'b0) begin n_errors++; $display("FAIL deg_steps0_busy got %b exp 0", tv.busy); end
    do_tick();
    n_checks++; if (tv.vel !== 16'(40) || tv.vel_valid !== 1'b1) begin n_errors++; $display("FAIL deg_steps0 got vel %0d vv %b exp 40 1", $signed(tv.vel), tv.vel_valid); end
    send_cmd(2'b00, 9, 5);
    n_checks++; if (tv.busy !== 1'b0) begin n_errors++; $display("FAIL deg_hold_busy got %b exp 0", tv.busy); end
    do_tick();
    n_checks++; if (tv.vel !== 16'(40)) begin n_errors++; $display("FAIL deg_hold got %0d exp 40", $signed(tv.vel)); end
    send_cmd(2'b10, 255, 129);
    for (int i = 0; i < 129; i++) do_tick();
    n_checks++; if (tv.vel !== 16'(-32768) || tv.sat !== 1'b1) begin n_errors++; $display("FAIL deg_neg_sat got vel %0d sat %b exp -32768 1", $signed(tv.vel), tv.sat); end
    send_cmd(2'b11, 0, 0);
    n_checks++; if (tv.busy !== 1'b1) begin n_errors++; $display("FAIL deg_brake_busy got %b exp 1", tv.busy); end
    do_tick();
    n_checks++; if (tv.vel !== 16'(0) || tv.busy !== 1'b0) begin n_errors++; $display("FAIL deg_brake0 got vel %0d busy %b exp 0 0", $signed(tv.vel), tv.busy); end
  endtask

  task automatic test_back_to_back();
    // Command, tick and abort together in IDLE: accepted, not yet applied.
    tv.cmd_valid = 1'b1; tv.cmd_mode = 2'b01; tv.cmd_accel = 8'd3; tv.cmd_steps = 8'd2;
    tv.tick = 1'b1; tv.cmd_abort = 1'b1;
    step();
    tv.cmd_valid = 1'b0; tv.tick = 1'b0; tv.cmd_abort = 1'b0;
    n_checks++; if (tv.vel !== 16'(0) || tv.vel_valid !== 1'b1 || tv.busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept got vel %0d vv %b busy %b exp 0 1 1", $signed(tv.vel), tv.vel_valid, tv.busy); end
    do_tick(); do_tick();
    n_checks++; if (tv.vel !== 16'(6) || tv.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_run got vel %0d busy %b exp 6 0", $signed(tv.vel), tv.busy); end
    send_cmd(2'b10, 6, 1);
    do_tick();
    n_checks++; if (tv.vel !== 16'(0)) begin n_errors++; $display("FAIL b2b_second got %0d exp 0", $signed(tv.vel)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      tv.tick      = ($urandom_range(0, 2) == 0);
      tv.cmd_valid = ($urandom_range(0, 3) == 0);
      tv.cmd_mode  = 2'($urandom_range(0, 3));
      tv.cmd_accel = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 40));
      tv.cmd_steps = AW'($urandom_range(0, 12));
      tv.cmd_abort = ($urandom_range(0, 24) == 0);
      step();
      n_checks++; if (tv.vel !== 16'(m_vel)) begin n_errors++; $display("FAIL rnd_vel cyc %0d got %0d exp %0d", i, $signed(tv.vel), m_vel); end
      n_checks++; if (tv.vel_valid !== m_vv) begin n_errors++; $display("FAIL rnd_vv cyc %0d got %b exp %b", i, tv.vel_valid, m_vv); end
      n_checks++; if (tv.busy !== m_busy) begin n_errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", i, tv.busy, m_busy); end
      n_checks++; if (tv.sat !== m_sat) begin n_errors++; $display("FAIL rnd_sat cyc %0d got %b exp %b", i, tv.sat, m_sat); end
      n_checks++; if (tv.cmd_ready !== (!m_busy && !rst)) begin n_errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, tv.cmd_ready, (!m_busy && !rst)); end
    end
    rst = 1'b0; tv.tick = 1'b0; tv.cmd_valid = 1'b0; tv.cmd_abort = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_accel();
    test_saturation();
    test_brake();
    test_abort();
    test_reset_mid();
    test_degenerate();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
